image_loader: RTL and testbench
===============================

IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 SHALL have parameter IMG_W, default 28, image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 28, image height in pixels.
REQ-003 SHALL have parameter BUS_W, default 8, pixel bits per input beat; IMG_W*IMG_H SHALL be a multiple of BUS_W (elaboration error otherwise).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 state  input  3  top-level controller state (S_IDLE=0, S_LOAD=1, S_LAYER_1=2, S_LAYER_2=3, S_LAYER_3=4).
REQ-007 data_in  input  BUS_W  packed binarized pixels, bit i = pixel 8k+i of beat k (LSB first).
REQ-008 data_valid  input  1  data_in valid this cycle.
REQ-009 data_ready  output  1  loader accepts a beat this cycle.
REQ-010 load_done  output  1  full image captured; consumed by controller to leave S_LOAD.
REQ-011 rd_row  input  5  pixel row read address.
REQ-012 rd_col  input  5  pixel column read address.
REQ-013 rd_pixel  output  1  stored pixel at (rd_row, rd_col), combinational.

Function
REQ-014 Beat accepted iff data_valid & data_ready; data_ready SHALL equal (state==S_LOAD) & ~full.
REQ-015 Accepted beat k (0..NBEATS-1, NBEATS=IMG_W*IMG_H/BUS_W=98) SHALL write data_in into pixel indices BUS_W*k..BUS_W*k+BUS_W-1; pixel index = row*IMG_W+col.
REQ-016 Beat counter SHALL increment by 1 per accepted beat; on accepting beat NBEATS-1 it SHALL set internal flag full on the same edge and not wrap.
REQ-017 load_done SHALL equal full & (state==S_LOAD): high from the cycle after the last beat is accepted until state leaves S_LOAD.
REQ-018 Beats with data_valid while state!=S_LOAD or full SHALL be ignored; buffer and counter unchanged.
REQ-019 When state==S_IDLE, counter and full SHALL clear next edge; buffer contents SHALL be retained until overwritten by the next load.
REQ-020 In S_LAYER_1..S_LAYER_3 counter, full and buffer SHALL hold.
REQ-021 rd_pixel SHALL return 0 when rd_row>=IMG_H or rd_col>=IMG_W (zero padding for layer-1 windows), else stored bit, zero-latency.
REQ-022 Read during the write edge to the same pixel SHALL return the pre-edge value.
REQ-023 If state leaves S_LOAD with full==0 (abort), partial data SHALL be kept, counter holds; re-entry to S_LOAD continues at the held count unless S_IDLE was passed.

Reset
REQ-024 On rst_n==0 at a clock edge: counter=0, full=0, all buffer bits=0, data_ready=0 next cycle only if state!=S_LOAD, load_done=0.
REQ-025 Reset mid-load SHALL discard all captured beats; next load starts at beat 0.

Configuration
REQ-026 Macro IMAGE_LOADER_OVERRUN_EN: when defined, SHALL add output overrun (1 bit) set sticky when data_valid is high while state==S_LOAD and full==1, cleared only by reset or S_IDLE; when undefined, port and logic SHALL be absent and such beats silently dropped.

Structure
REQ-027 Package bnn_pkg SHALL hold state encodings S_IDLE..S_LAYER_3, IMG_W, IMG_H, BUS_W defaults and NBEATS; controller and loader SHALL import it.
REQ-028 Sub-module pixel_buffer SHALL hold the IMG_W*IMG_H-bit store with one BUS_W-wide beat write port and one bit read port; control (counter, full, handshake) stays in image_loader.

Verification
REQ-029 Reset, state=S_LOAD, 98 beats of 8'hA5 with data_valid=1 -> data_ready low and load_done high from cycle 99; rd_pixel(0,0)=1, (0,1)=0, (27,27)=1.
REQ-030 Beat k = k[7:0] with data_valid toggling every other cycle -> load_done only after 98th accepted beat; rd_pixel(row,col) matches bit of index row*28+col.
REQ-031 data_valid=1 with state=S_IDLE or S_LAYER_2 -> data_ready=0, buffer unchanged, load_done=0.
REQ-032 rst_n low after 50 beats, then 98 beats of 8'hFF -> load_done after exactly 98 beats; all in-range pixels 1.
REQ-033 rd_row=28 or rd_col=31 after full load of 8'hFF -> rd_pixel=0.
REQ-034 With IMAGE_LOADER_OVERRUN_EN: 99th beat in S_LOAD -> overrun=1 and holds; cleared after state=S_IDLE.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared controller state encodings and default image geometry for the BNN datapath.
package bnn_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_LAYER_1 = 3'd2,
    S_LAYER_2 = 3'd3,
    S_LAYER_3 = 3'd4
  } state_t;

  localparam int DEF_IMG_W  = 28;
  localparam int DEF_IMG_H  = 28;
  localparam int DEF_BUS_W  = 8;
  localparam int DEF_NBEATS = DEF_IMG_W * DEF_IMG_H / DEF_BUS_W;

  // Index width for a range of n entries, never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_buffer.sv
// Binarized image store: one beat-wide write port, one single-pixel combinational read port.
module pixel_buffer
  import bnn_pkg::*;
#(
  parameter  int NBEATS = DEF_NBEATS,
  parameter  int BUS_W  = DEF_BUS_W,
  localparam int CNT_W  = idx_width(NBEATS),
  localparam int IDX_W  = idx_width(NBEATS * BUS_W),
  localparam int SEL_W  = idx_width(BUS_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_beat,
  input  logic [BUS_W-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_bit
);

  logic [BUS_W-1:0] mem [NBEATS];
  logic [CNT_W-1:0] rd_beat;
  logic [SEL_W-1:0] rd_sel;
  logic [BUS_W-1:0] rd_word;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NBEATS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_beat] <= wr_data;
    end
  end

  always_comb begin
    rd_beat = CNT_W'(rd_idx / IDX_W'(BUS_W));
    rd_sel  = SEL_W'(rd_idx % IDX_W'(BUS_W));
    rd_word = mem[rd_beat];
    rd_bit  = rd_word[rd_sel];
  end

endmodule

// File: rtl/image_loader.sv
// Captures one binarized image beat-by-beat while the controller is in S_LOAD and serves
// zero-padded pixel reads. Optional sticky overrun flag: define IMAGE_LOADER_OVERRUN_EN.
module image_loader
  import bnn_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int BUS_W = DEF_BUS_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       state,
  input  logic [BUS_W-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             load_done,
  input  logic [4:0]       rd_row,
  input  logic [4:0]       rd_col,
  output logic             rd_pixel
`ifdef IMAGE_LOADER_OVERRUN_EN
  ,
  output logic             overrun
`endif
);

  localparam int NPIX   = IMG_W * IMG_H;
  localparam int NBEATS = NPIX / BUS_W;
  localparam int CNT_W  = idx_width(NBEATS);
  localparam int IDX_W  = idx_width(NPIX);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  if ((NPIX % BUS_W) != 0) begin : g_bad_geometry
    $error("image_loader: IMG_W*IMG_H must be a multiple of BUS_W");
  end

  state_t           st;
  logic [CNT_W-1:0] beat_cnt;
  logic             full;
  logic             accept;
  logic             in_range;
  logic [IDX_W-1:0] rd_idx;
  logic             buf_bit;

  assign st         = state_t'(state);
  assign data_ready = (st == S_LOAD) && !full;
  assign accept     = data_valid && data_ready;
  assign load_done  = full && (st == S_LOAD);

  // The counter parks on the last beat; full alone marks completion so it never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      full     <= 1'b0;
    end else begin
      case (st)
        S_IDLE: begin
          beat_cnt <= '0;
          full     <= 1'b0;
        end
        S_LOAD: begin
          if (accept) begin
            if (beat_cnt == LAST_BEAT) full <= 1'b1;
            else                       beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IMAGE_LOADER_OVERRUN_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                                    overrun <= 1'b0;
    else if (st == S_IDLE)                         overrun <= 1'b0;
    else if ((st == S_LOAD) && full && data_valid) overrun <= 1'b1;
  end
`endif

  // Out-of-window reads are forced to zero and steered to address 0 to stay inside the store.
  always_comb begin
    in_range = (32'(rd_row) < 32'(IMG_H)) && (32'(rd_col) < 32'(IMG_W));
    rd_idx   = in_range ? IDX_W'(32'(rd_row) * 32'(IMG_W) + 32'(rd_col)) : '0;
    rd_pixel = in_range && buf_bit;
  end

  pixel_buffer #(
    .NBEATS (NBEATS),
    .BUS_W  (BUS_W)
  ) u_pixel_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept),
    .wr_beat (beat_cnt),
    .wr_data (data_in),
    .rd_idx  (rd_idx),
    .rd_bit  (buf_bit)
  );

endmodule

// File: tb/tb_image_loader.sv
// Self-checking bench for image_loader: directed sequences, a read table and randomized traffic
// compared against an image-level reference model.
module tb_image_loader;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_L1   = 3'd2;
  localparam logic [2:0] ST_L2   = 3'd3;
  localparam logic [2:0] ST_L3   = 3'd4;
  localparam int W = 28;
  localparam int H = 28;
  localparam int NB = W * H / 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] state;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       load_done;
  logic [4:0] rd_row;
  logic [4:0] rd_col;
  logic       rd_pixel;
`ifdef IMAGE_LOADER_OVERRUN_EN
  logic       overrun;
`endif

  always #5 clk = ~clk;

  image_loader #(.IMG_W(28), .IMG_H(28), .BUS_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .state      (state),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .load_done  (load_done),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_pixel   (rd_pixel)
`ifdef IMAGE_LOADER_OVERRUN_EN
    ,
    .overrun    (overrun)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference: the image as a flat pixel array plus the number of beats taken so far.
  bit m_img [W*H];
  int m_taken;
  bit m_ovr;

  function automatic bit m_ready(input logic [2:0] s);
    return (s == ST_LOAD) && (m_taken < NB);
  endfunction

  function automatic bit m_done(input logic [2:0] s);
    return (s == ST_LOAD) && (m_taken == NB);
  endfunction

  function automatic bit m_pix(input int r, input int c);
    if (r >= H || c >= W) return 1'b0;
    return m_img[r*W + c];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, compare pre-edge outputs with the model, then advance the model.
  task automatic cyc(input logic r, input logic [2:0] s, input logic v, input logic [7:0] d,
                     input int row, input int col, input bit check);
    rst_n = r; state = s; data_valid = v; data_in = d;
    rd_row = 5'(row); rd_col = 5'(col);
    @(negedge clk);
    if (check) begin
      chk("data_ready", 32'(data_ready), 32'(m_ready(s)));
      chk("load_done",  32'(load_done),  32'(m_done(s)));
      chk("rd_pixel",   32'(rd_pixel),   32'(m_pix(row, col)));
`ifdef IMAGE_LOADER_OVERRUN_EN
      chk("overrun",    32'(overrun),    32'(m_ovr));
`endif
    end
    if (!r) begin
      foreach (m_img[i]) m_img[i] = 1'b0;
      m_taken = 0;
      m_ovr   = 1'b0;
    end else if (s == ST_IDLE) begin
      m_taken = 0;
      m_ovr   = 1'b0;
    end else if (s == ST_LOAD && v) begin
      if (m_taken < NB) begin
        for (int i = 0; i < 8; i++) m_img[m_taken*8 + i] = d[i];
        m_taken++;
      end else begin
        m_ovr = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sweep();
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++)
        cyc(1'b1, ST_L1, 1'($urandom), 8'($urandom), r, c, 1'b1);
  endtask

  typedef struct {
    int row;
    int col;
    bit exp;
  } rd_vec_t;

  rd_vec_t tbl [9];

  initial begin
    int acc;
    logic [2:0] s;

    // 0xA5 = 1010_0101: pixel index i is 1 when i%8 is 0, 2, 5 or 7.
    tbl[0] = '{0, 0, 1'b1};
    tbl[1] = '{0, 1, 1'b0};
    tbl[2] = '{0, 2, 1'b1};
    tbl[3] = '{0, 7, 1'b1};
    tbl[4] = '{1, 0, 1'b0};
    tbl[5] = '{13, 5, 1'b0};
    tbl[6] = '{27, 27, 1'b1};
    tbl[7] = '{28, 0, 1'b0};
    tbl[8] = '{5, 31, 1'b0};

    foreach (m_img[i]) m_img[i] = 1'b0;
    m_taken = 0;
    m_ovr   = 1'b0;

    // Reset, state undefined beforehand so the first cycle is unchecked.
    cyc(1'b0, ST_IDLE, 1'b0, 8'h00, 0, 0, 1'b0);
    cyc(1'b0, ST_LOAD, 1'b1, 8'hFF, 0, 0, 1'b0);
    chk("rst_ready_load", 32'(data_ready), 32'd1);
    chk("rst_done", 32'(load_done), 32'd0);

    // Full load of 0xA5.
    for (int k = 0; k < NB; k++) cyc(1'b1, ST_LOAD, 1'b1, 8'hA5, k % 28, k % 31, 1'b1);
    chk("a5_done", 32'(load_done), 32'd1);
    chk("a5_ready", 32'(data_ready), 32'd0);
    foreach (tbl[i]) begin
      rd_row = 5'(tbl[i].row); rd_col = 5'(tbl[i].col);
      data_valid = 1'b0; state = ST_LOAD;
      @(negedge clk);
      chk($sformatf("a5_tbl[%0d]", i), 32'(rd_pixel), 32'(tbl[i].exp));
      @(posedge clk); #1;
    end

    // Extra beat after full: dropped, overrun (when present) sticks until S_IDLE.
    cyc(1'b1, ST_LOAD, 1'b1, 8'h00, 0, 0, 1'b1);
    cyc(1'b1, ST_L1, 1'b0, 8'h00, 0, 0, 1'b1);
    chk("after_extra_pix00", 32'(rd_pixel), 32'd1);
`ifdef IMAGE_LOADER_OVERRUN_EN
    chk("overrun_sticky", 32'(overrun), 32'd1);
`endif
    cyc(1'b1, ST_IDLE, 1'b1, 8'h00, 0, 0, 1'b1);
`ifdef IMAGE_LOADER_OVERRUN_EN
    chk("overrun_cleared", 32'(overrun), 32'd0);
`endif
    chk("idle_ready", 32'(data_ready), 32'd0);
    chk("idle_keeps_pix", 32'(rd_pixel), 32'd1);

    // Beat k = k with data_valid toggling.
    acc = 0;
    for (int n = 0; n < 2*NB + 4; n++) begin
      cyc(1'b1, ST_LOAD, 1'(n % 2 == 0), 8'(acc), $urandom_range(0, 31), $urandom_range(0, 31), 1'b1);
      if (n % 2 == 0 && acc < NB) acc++;
      if (acc == NB - 1) chk("toggle_not_done", 32'(load_done), 32'd0);
    end
    chk("toggle_done", 32'(load_done), 32'd1);
    sweep();

    // Valid beats outside S_LOAD are ignored.
    for (int n = 0; n < 6; n++) begin
      s = (n % 2 == 0) ? ST_L2 : ST_IDLE;
      cyc(1'b1, s, 1'b1, 8'($urandom), n, 2*n, 1'b1);
      chk("nonload_ready", 32'(data_ready), 32'd0);
      chk("nonload_done", 32'(load_done), 32'd0);
    end

    // Reset mid-load, then a fresh 0xFF load.
    for (int k = 0; k < 50; k++) cyc(1'b1, ST_LOAD, 1'b1, 8'($urandom), 0, k % 28, 1'b1);
    cyc(1'b0, ST_LOAD, 1'b1, 8'h00, 0, 0, 1'b1);
    for (int k = 0; k < NB; k++) begin
      chk("ff_not_done", 32'(load_done), 32'd0);
      cyc(1'b1, ST_LOAD, 1'b1, 8'hFF, 27 - (k % 28), k % 28, 1'b1);
    end
    chk("ff_done", 32'(load_done), 32'd1);
    cyc(1'b1, ST_L3, 1'b0, 8'h00, 28, 0, 1'b1);
    chk("pad_row28", 32'(rd_pixel), 32'd0);
    cyc(1'b1, ST_L3, 1'b0, 8'h00, 0, 31, 1'b1);
    chk("pad_col31", 32'(rd_pixel), 32'd0);
    cyc(1'b1, ST_L3, 1'b0, 8'h00, 27, 0, 1'b1);
    chk("ff_pix27_0", 32'(rd_pixel), 32'd1);
    sweep();

    // Abort mid-load and resume at the held count.
    cyc(1'b1, ST_IDLE, 1'b0, 8'h00, 0, 0, 1'b1);
    for (int k = 0; k < 30; k++) cyc(1'b1, ST_LOAD, 1'b1, 8'h3C, 0, 0, 1'b1);
    for (int k = 0; k < 5; k++) cyc(1'b1, ST_L1, 1'b1, 8'h00, 1, k, 1'b1);
    for (int k = 0; k < NB - 30; k++) cyc(1'b1, ST_LOAD, 1'b1, 8'hC3, 20, k % 28, 1'b1);
    chk("resume_done", 32'(load_done), 32'd1);

    // Randomized traffic.
    for (int n = 0; n < 2500; n++) begin
      int p;
      p = $urandom_range(0, 99);
      if (p < 3)       s = ST_IDLE;
      else if (p < 75) s = ST_LOAD;
      else if (p < 83) s = ST_L1;
      else if (p < 91) s = ST_L2;
      else             s = ST_L3;
      cyc(1'($urandom_range(0, 199) != 0), s, 1'($urandom_range(0, 3) != 0), 8'($urandom),
          $urandom_range(0, 29), $urandom_range(0, 29), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
